// File: rtl/caliptra_prim_reqack_dst_rx_buf_pkg.sv
// ============================================================================
// Module  : caliptra_prim_reqack_dst_rx_buf_pkg
// Brief   : Helper function for sizing the DST-side receive buffer pointers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package caliptra_prim_reqack_dst_rx_buf_pkg;

  // A single-entry buffer still needs a 1-bit pointer; it simply never moves.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/caliptra_prim_reqack_dst_rx_buf_if.sv
// ============================================================================
// Module  : caliptra_prim_reqack_dst_rx_buf_if
// Brief   : REQ/ACK ingress plus valid/ready egress of the DST receive buffer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface caliptra_prim_reqack_dst_rx_buf_if #(
  parameter int Width = 32
);
  logic             dst_req;
  logic             dst_ack;
  logic [Width-1:0] dst_data;
  logic             valid;
  logic             ready;
  logic [Width-1:0] data;

  // master: synchronizer + consumer side; slave: the buffer itself
  modport master (output dst_req, dst_data, ready, input dst_ack, valid, data);
  modport slave  (input dst_req, dst_data, ready, output dst_ack, valid, data);
endinterface

`default_nettype wire

// File: rtl/caliptra_prim_reqack_dst_rx_buf.sv
// ============================================================================
// Module  : caliptra_prim_reqack_dst_rx_buf
// Brief   : DST-domain REQ/ACK receive FIFO; ACK is withheld while full.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module caliptra_prim_reqack_dst_rx_buf
  import caliptra_prim_reqack_dst_rx_buf_pkg::*;
#(
  parameter int Width = 32,
  parameter int Depth = 2
) (
  input  wire logic                       clk_dst_i,
  input  wire logic                       rst_dst_ni,
  input  wire logic                       flush_i,
  caliptra_prim_reqack_dst_rx_buf_if.slave bus,
  output logic [$clog2(Depth+1)-1:0]      count_o,
  output logic                            full_o
);

  localparam int              PtrW    = ptr_width(Depth);
  localparam int              CntW    = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] PtrMax  = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             init_q, init_d;
  logic             full, valid, push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrMax) ? '0 : p + 1'b1;
  endfunction

  assign full  = (cnt_q == CntFull);
  assign valid = (cnt_q != '0);
  assign pop   = valid & bus.ready & ~flush_i;
  // init_q keeps ACK low on the first cycle after reset release
  assign push  = init_q & bus.dst_req & ~flush_i & (~full | pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    init_d   = 1'b1;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = bus.dst_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_dst_i or negedge rst_dst_ni) begin
    if (!rst_dst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      init_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      init_q   <= init_d;
    end
  end

  assign bus.dst_ack = push;
  assign bus.valid   = valid;
  assign bus.data    = mem_q[rd_ptr_q];
  assign count_o     = cnt_q;
  assign full_o      = full;

`ifdef CALIPTRA_INC_ASSERT
  a_data_stable: assert property (@(posedge clk_dst_i) disable iff (!rst_dst_ni)
    (bus.dst_req && !bus.dst_ack) |=> (!bus.dst_req || $stable(bus.dst_data)));
  a_no_overflow: assert property (@(posedge clk_dst_i) disable iff (!rst_dst_ni)
    !(push && full && !pop));
  a_no_underflow: assert property (@(posedge clk_dst_i) disable iff (!rst_dst_ni)
    !(pop && !valid));
  a_count_range: assert property (@(posedge clk_dst_i) disable iff (!rst_dst_ni)
    cnt_q <= CntFull);
`endif

endmodule

`default_nettype wire

// File: tb/tb_caliptra_prim_reqack_dst_rx_buf.sv
// ============================================================================
// Module  : tb_caliptra_prim_reqack_dst_rx_buf
// Brief   : Directed bench for the DST receive buffer at Depth=2 and Depth=3.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_caliptra_prim_reqack_dst_rx_buf;

  logic       clk_dst_i;
  logic       rst_dst_ni;
  logic       flush_a, flush_b;
  logic [1:0] count_a;
  logic [2:0] count_b;
  logic       full_a, full_b;
  int         n_cmp;
  int         n_err;

  caliptra_prim_reqack_dst_rx_buf_if #(.Width(32)) ia ();
  caliptra_prim_reqack_dst_rx_buf_if #(.Width(32)) ib ();

  caliptra_prim_reqack_dst_rx_buf #(.Width(32), .Depth(2)) u_dut_a (
    .clk_dst_i (clk_dst_i),
    .rst_dst_ni(rst_dst_ni),
    .flush_i   (flush_a),
    .bus       (ia.slave),
    .count_o   (count_a),
    .full_o    (full_a)
  );

  caliptra_prim_reqack_dst_rx_buf #(.Width(32), .Depth(3)) u_dut_b (
    .clk_dst_i (clk_dst_i),
    .rst_dst_ni(rst_dst_ni),
    .flush_i   (flush_b),
    .bus       (ib.slave),
    .count_o   (count_b),
    .full_o    (full_b)
  );

  initial clk_dst_i = 1'b0;
  always #5 clk_dst_i = ~clk_dst_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_dst_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_dst_ni = 1'b0;
    flush_a = 1'b0; flush_b = 1'b0;
    ia.dst_req = 1'b1; ia.dst_data = 32'h0; ia.ready = 1'b0;
    ib.dst_req = 1'b0; ib.dst_data = 32'h0; ib.ready = 1'b0;

    // reset state, REQ high during reset must not be ACKed
    #3;
    chk("rst_ack",   32'(ia.dst_ack), 32'd0);
    chk("rst_valid", 32'(ia.valid),   32'd0);
    chk("rst_count", 32'(count_a),    32'd0);
    chk("rst_full",  32'(full_a),     32'd0);
    chk("rst_data",  ia.data,         32'h0);
    ia.dst_req = 1'b0;
    tick(); tick();
    rst_dst_ni = 1'b1;
    ia.dst_req = 1'b1;
    #1 chk("rel_first_ack", 32'(ia.dst_ack), 32'd0);
    ia.dst_req = 1'b0;
    tick();

    // single transfer, 1-cycle latency
    ia.dst_req = 1'b1; ia.dst_data = 32'hA5A5_0001;
    #1 chk("t1_ack", 32'(ia.dst_ack), 32'd1);
    tick();
    ia.dst_req = 1'b0;
    #1;
    chk("t1_valid", 32'(ia.valid), 32'd1);
    chk("t1_data",  ia.data,       32'hA5A5_0001);
    chk("t1_count", 32'(count_a),  32'd1);
    ia.ready = 1'b1;
    tick();
    ia.ready = 1'b0;
    #1 chk("t1_drain", 32'(count_a), 32'd0);

    // back-pressure at Depth=2
    ia.dst_req = 1'b1; ia.dst_data = 32'h1;
    #1 chk("t2_ack1", 32'(ia.dst_ack), 32'd1);
    tick();
    ia.dst_data = 32'h2;
    #1 chk("t2_ack2", 32'(ia.dst_ack), 32'd1);
    tick();
    ia.dst_data = 32'h3;
    #1;
    chk("t2_ack3_held", 32'(ia.dst_ack), 32'd0);
    chk("t2_full",      32'(full_a),     32'd1);
    chk("t2_count",     32'(count_a),    32'd2);
    tick();
    chk("t2_still_held", 32'(ia.dst_ack), 32'd0);
    ia.ready = 1'b1;
    #1;
    chk("t2_pop_ack", 32'(ia.dst_ack), 32'd1);
    chk("t2_out1",    ia.data,         32'h1);
    tick();
    ia.dst_req = 1'b0;
    #1;
    chk("t2_out2",   ia.data,      32'h2);
    chk("t2_count2", 32'(count_a), 32'd2);
    tick();
    chk("t2_out3",   ia.data,      32'h3);
    chk("t2_count3", 32'(count_a), 32'd1);
    tick();
    ia.ready = 1'b0;
    #1 chk("t2_empty", 32'(ia.valid), 32'd0);

    // push and pop together at count 1
    ia.dst_req = 1'b1; ia.dst_data = 32'h11;
    tick();
    ia.dst_req = 1'b0;
    #1 chk("t3_head11", ia.data, 32'h11);
    ia.dst_req = 1'b1; ia.dst_data = 32'h22; ia.ready = 1'b1;
    #1 chk("t3_ack", 32'(ia.dst_ack), 32'd1);
    tick();
    ia.dst_req = 1'b0; ia.ready = 1'b0;
    #1;
    chk("t3_count", 32'(count_a),  32'd1);
    chk("t3_valid", 32'(ia.valid), 32'd1);
    chk("t3_head22", ia.data,      32'h22);
    ia.ready = 1'b1;
    tick();
    ia.ready = 1'b0;

    // flush while full with REQ pending
    ia.dst_req = 1'b1; ia.dst_data = 32'hA;
    tick();
    ia.dst_data = 32'hB;
    tick();
    ia.dst_data = 32'hC;
    #1 chk("t4_full", 32'(full_a), 32'd1);
    flush_a = 1'b1;
    #1 chk("t4_flush_ack", 32'(ia.dst_ack), 32'd0);
    tick();
    flush_a = 1'b0;
    #1;
    chk("t4_count0", 32'(count_a),    32'd0);
    chk("t4_valid0", 32'(ia.valid),   32'd0);
    chk("t4_ack",    32'(ia.dst_ack), 32'd1);
    tick();
    ia.dst_req = 1'b0;
    #1;
    chk("t4_count1", 32'(count_a), 32'd1);
    chk("t4_head",   ia.data,      32'hC);
    ia.ready = 1'b1;
    tick();
    ia.ready = 1'b0;

    // Depth=3: fill, then stream with wrap, then drain
    for (int i = 0; i < 3; i++) begin
      ib.dst_req = 1'b1; ib.dst_data = 32'h100 + 32'(i);
      #1 chk("t5_fill_ack", 32'(ib.dst_ack), 32'd1);
      tick();
    end
    chk("t5_full",  32'(full_b),  32'd1);
    chk("t5_count", 32'(count_b), 32'd3);
    ib.ready = 1'b1;
    for (int i = 3; i < 10; i++) begin
      ib.dst_data = 32'h100 + 32'(i);
      #1;
      chk("t5_stream_data", ib.data,         32'h100 + 32'(i - 3));
      chk("t5_stream_ack",  32'(ib.dst_ack), 32'd1);
      tick();
    end
    ib.dst_req = 1'b0;
    for (int j = 7; j < 10; j++) begin
      #1 chk("t5_drain_data", ib.data, 32'h100 + 32'(j));
      tick();
    end
    ib.ready = 1'b0;
    #1;
    chk("t5_count0", 32'(count_b),  32'd0);
    chk("t5_valid0", 32'(ib.valid), 32'd0);

    // async reset with two words buffered and REQ pending
    ia.dst_req = 1'b1; ia.dst_data = 32'h55;
    tick();
    ia.dst_data = 32'h66;
    tick();
    ia.dst_data = 32'h77;
    #1 chk("t6_held", 32'(ia.dst_ack), 32'd0);
    #1 rst_dst_ni = 1'b0;
    #1;
    chk("t6_valid", 32'(ia.valid),   32'd0);
    chk("t6_count", 32'(count_a),    32'd0);
    chk("t6_ack",   32'(ia.dst_ack), 32'd0);
    chk("t6_full",  32'(full_a),     32'd0);
    chk("t6_data",  ia.data,         32'h0);
    tick();
    chk("t6_ack_in_rst", 32'(ia.dst_ack), 32'd0);
    rst_dst_ni = 1'b1;
    #1 chk("t6_ack_first", 32'(ia.dst_ack), 32'd0);
    tick();
    chk("t6_ack_after", 32'(ia.dst_ack), 32'd1);
    tick();
    ia.dst_req = 1'b0;
    #1;
    chk("t6_count1", 32'(count_a), 32'd1);
    chk("t6_head",   ia.data,      32'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
